// File: rtl/elbeth_memory_responder_if.sv
// Memory port bundle between an initiator (core imem/dmem) and the memory responder.
interface elbeth_memory_responder_if #(
  parameter int unsigned ADDR_WIDTH = 12
);
  logic                  mem_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [3:0]            mem_rw;
  logic [31:0]           mem_in_data;
  logic [31:0]           mem_out_data;
  logic                  mem_ready;
  logic                  mem_error;

  modport master (
    output mem_en, mem_addr, mem_rw, mem_in_data,
    input  mem_out_data, mem_ready, mem_error
  );

  modport slave (
    input  mem_en, mem_addr, mem_rw, mem_in_data,
    output mem_out_data, mem_ready, mem_error
  );
endinterface

// File: rtl/elbeth_memory_responder.sv
// Word-organised RAM responder with byte-lane writes, programmable wait states and
// error flagging for out-of-range, illegal-mask and misaligned requests.
module elbeth_memory_responder #(
  parameter int unsigned ADDR_WIDTH      = 12,
  parameter int unsigned MEM_DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES     = 1
) (
  input logic                      clk,
  input logic                      rst,
  elbeth_memory_responder_if.slave bus
);

  localparam int unsigned          IdxW      = $clog2(MEM_DEPTH_WORDS);
  localparam logic [ADDR_WIDTH:0]  AddrLimit = (ADDR_WIDTH + 1)'(MEM_DEPTH_WORDS * 4);
  localparam logic [3:0]           WaitInit  = 4'(WAIT_STATES);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            rw_q;
  logic [31:0]           wdata_q;
  logic                  ready_q;
  logic                  err_q;
  logic [31:0]           rdata_q;

  logic [31:0] ram [MEM_DEPTH_WORDS];

  logic [ADDR_WIDTH-1:0] req_addr;
  logic [3:0]            req_rw;
  logic                  req_bad;
  logic                  enter_resp;

  function automatic logic req_err(input logic [ADDR_WIDTH-1:0] addr, input logic [3:0] rw);
    logic oor;
    logic bad_mask;
    logic misalign;
    oor = {1'b0, addr} >= AddrLimit;
    case (rw)
      4'b0000, 4'b0001, 4'b0010, 4'b0100,
      4'b1000, 4'b0011, 4'b1100, 4'b1111: bad_mask = 1'b0;
      default:                            bad_mask = 1'b1;
    endcase
    misalign = ((rw == 4'b0011 || rw == 4'b1100 || rw == 4'b1111) && addr[0]) ||
               (rw == 4'b1111 && addr[1]);
    return oor | bad_mask | misalign;
  endfunction

  // With zero wait states the response is built straight from the bus at capture time.
  always_comb begin
    req_addr   = (state_q == StIdle) ? bus.mem_addr : addr_q;
    req_rw     = (state_q == StIdle) ? bus.mem_rw   : rw_q;
    req_bad    = req_err(req_addr, req_rw);
    enter_resp = ((state_q == StIdle) && bus.mem_en && (WaitInit == 4'd0)) ||
                 ((state_q == StWait) && (cnt_q == 4'd1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      rw_q    <= 4'd0;
      wdata_q <= 32'h0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      ready_q <= enter_resp;
      err_q   <= enter_resp ? req_bad : 1'b0;
      if (enter_resp) begin
        rdata_q <= req_bad ? 32'h0 : ram[req_addr[IdxW+1:2]];
      end
      unique case (state_q)
        StIdle: begin
          if (bus.mem_en) begin
            addr_q  <= bus.mem_addr;
            rw_q    <= bus.mem_rw;
            wdata_q <= bus.mem_in_data;
            cnt_q   <= WaitInit;
            state_q <= (WaitInit == 4'd0) ? StResp : StWait;
          end
        end
        StWait: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= StResp;
          end
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Commit on the edge ending RESP; an asynchronous reset leaves StResp first, aborting it.
  always_ff @(posedge clk) begin
    if (state_q == StResp && !err_q) begin
      for (int i = 0; i < 4; i++) begin
        if (rw_q[i]) begin
          ram[addr_q[IdxW+1:2]][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign bus.mem_ready    = ready_q;
  assign bus.mem_error    = err_q;
  assign bus.mem_out_data = rdata_q;

endmodule

// File: tb/tb_elbeth_memory_responder.sv
// Scoreboard bench: dut_a (512 words, 1 wait state) and dut_b (1024 words, 0 wait states).
module tb_elbeth_memory_responder;

  typedef struct {
    logic        err;
    logic [31:0] data;
    bit          chk;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   prev_ready_b = 1'b0;

  exp_t        qa[$];
  exp_t        qb[$];
  logic [31:0] model [int];

  elbeth_memory_responder_if #(.ADDR_WIDTH(12)) bus_a ();
  elbeth_memory_responder_if #(.ADDR_WIDTH(12)) bus_b ();

  elbeth_memory_responder #(
    .ADDR_WIDTH      (12),
    .MEM_DEPTH_WORDS (512),
    .WAIT_STATES     (1)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  elbeth_memory_responder #(
    .ADDR_WIDTH      (12),
    .MEM_DEPTH_WORDS (1024),
    .WAIT_STATES     (0)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit sel, input logic en, input logic [11:0] addr,
                       input logic [3:0] rw, input logic [31:0] data);
    if (sel) begin
      bus_b.mem_en = en; bus_b.mem_addr = addr; bus_b.mem_rw = rw; bus_b.mem_in_data = data;
    end else begin
      bus_a.mem_en = en; bus_a.mem_addr = addr; bus_a.mem_rw = rw; bus_a.mem_in_data = data;
    end
  endtask

  // Push the expected response and apply the write to the reference memory.
  task automatic expect_resp(input bit sel, input logic [11:0] addr, input logic [3:0] rw,
                             input logic [31:0] data, input bit exp_err, input int exp_cyc);
    exp_t e;
    int   key;
    key   = (sel ? 4096 : 0) + int'(addr[11:2]);
    e.err = exp_err;
    e.cyc = exp_cyc;
    if (exp_err) begin
      e.chk = 1'b1; e.data = 32'h0;
    end else if (model.exists(key)) begin
      e.chk = 1'b1; e.data = model[key];
    end else begin
      e.chk = 1'b0; e.data = 32'h0;
    end
    if (!exp_err && rw != 4'b0000) begin
      logic [31:0] w;
      w = model.exists(key) ? model[key] : 32'h0;
      for (int i = 0; i < 4; i++) if (rw[i]) w[8*i +: 8] = data[8*i +: 8];
      model[key] = w;
    end
    if (sel) qb.push_back(e);
    else     qa.push_back(e);
  endtask

  task automatic wait_idle(input bit sel);
    int pend;
    for (int i = 0; i < 20; i++) begin
      pend = sel ? qb.size() : qa.size();
      if (pend == 0) break;
      @(negedge clk);
    end
    pend = sel ? qb.size() : qa.size();
    if (pend != 0) begin
      check_eq(sel ? "b_timeout" : "a_timeout", 32'(pend), 32'd0);
      if (sel) qb.delete();
      else     qa.delete();
    end
  endtask

  task automatic req(input bit sel, input logic [11:0] addr, input logic [3:0] rw,
                     input logic [31:0] data, input bit exp_err);
    @(negedge clk);
    expect_resp(sel, addr, rw, data, exp_err, cyc + (sel ? 1 : 2));
    drive(sel, 1'b1, addr, rw, data);
    @(negedge clk);
    drive(sel, 1'b0, 12'h0, 4'b0000, 32'h0);
    wait_idle(sel);
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (rst) begin
      if (bus_a.mem_ready) begin
        if (qa.size() == 0) begin
          check_eq("a_unexpected_ready", 32'(qa.size()), 32'd1);
        end else begin
          e = qa.pop_front();
          check_eq("a_latency", 32'(cyc), 32'(e.cyc));
          check_eq("a_error", {31'b0, bus_a.mem_error}, {31'b0, e.err});
          if (e.chk) check_eq("a_data", bus_a.mem_out_data, e.data);
        end
      end else begin
        check_eq("a_error_no_ready", {31'b0, bus_a.mem_error}, 32'd0);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (rst) begin
      check_eq("b_no_b2b_ready", {31'b0, bus_b.mem_ready & prev_ready_b}, 32'd0);
      prev_ready_b = bus_b.mem_ready;
      if (bus_b.mem_ready) begin
        if (qb.size() == 0) begin
          check_eq("b_unexpected_ready", 32'(qb.size()), 32'd1);
        end else begin
          e = qb.pop_front();
          check_eq("b_latency", 32'(cyc), 32'(e.cyc));
          check_eq("b_error", {31'b0, bus_b.mem_error}, {31'b0, e.err});
          if (e.chk) check_eq("b_data", bus_b.mem_out_data, e.data);
        end
      end else begin
        check_eq("b_error_no_ready", {31'b0, bus_b.mem_error}, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    drive(1'b0, 1'b0, 12'h0, 4'b0000, 32'h0);
    drive(1'b1, 1'b0, 12'h0, 4'b0000, 32'h0);
    repeat (3) @(negedge clk);
    check_eq("rst_a_ready", {31'b0, bus_a.mem_ready}, 32'd0);
    check_eq("rst_a_error", {31'b0, bus_a.mem_error}, 32'd0);
    check_eq("rst_a_data", bus_a.mem_out_data, 32'h0);
    check_eq("rst_b_ready", {31'b0, bus_b.mem_ready}, 32'd0);
    check_eq("rst_b_data", bus_b.mem_out_data, 32'h0);
    rst = 1'b1;

    // Word write/read, then byte-lane merge (expect 32'hDEA5BEEF).
    req(0, 12'h004, 4'b1111, 32'hDEADBEEF, 0);
    req(0, 12'h004, 4'b0000, 32'h0, 0);
    req(0, 12'h004, 4'b0100, 32'h00A50000, 0);
    req(0, 12'h004, 4'b0000, 32'h0, 0);
    check_eq("lane_merge_model", model[1], 32'hDEA5BEEF);

    // Reset in the middle of WAIT for a write: it must not commit.
    req(0, 12'h010, 4'b1111, 32'h11111111, 0);
    @(negedge clk);
    drive(0, 1'b1, 12'h010, 4'b1111, 32'h22222222);
    @(negedge clk);
    drive(0, 1'b0, 12'h0, 4'b0000, 32'h0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_eq("midrst_ready", {31'b0, bus_a.mem_ready}, 32'd0);
      check_eq("midrst_error", {31'b0, bus_a.mem_error}, 32'd0);
      check_eq("midrst_data", bus_a.mem_out_data, 32'h0);
    end
    rst = 1'b1;
    req(0, 12'h010, 4'b0000, 32'h0, 0);

    // Error cases.
    req(0, 12'hFFC, 4'b0000, 32'h0, 1);
    req(0, 12'h800, 4'b0000, 32'h0, 1);
    req(0, 12'h7FC, 4'b1111, 32'h7777AAAA, 0);
    req(0, 12'h008, 4'b1111, 32'h0BADF00D, 0);
    req(0, 12'h008, 4'b0101, 32'hFFFFFFFF, 1);
    req(0, 12'h008, 4'b0000, 32'h0, 0);
    req(0, 12'h002, 4'b1111, 32'h12345678, 1);
    req(0, 12'h009, 4'b0011, 32'h12345678, 1);
    req(0, 12'h00A, 4'b1100, 32'h55660000, 0);
    req(0, 12'h008, 4'b0000, 32'h0, 0);

    // Handshake hold: en stays high, address changes during WAIT.
    req(0, 12'h018, 4'b1111, 32'hCAFEF00D, 0);
    req(0, 12'h020, 4'b1111, 32'h01234567, 0);
    @(negedge clk);
    expect_resp(0, 12'h018, 4'b0000, 32'h0, 0, cyc + 2);
    drive(0, 1'b1, 12'h018, 4'b0000, 32'h0);
    @(negedge clk);
    expect_resp(0, 12'h020, 4'b0000, 32'h0, 0, cyc + 4);
    drive(0, 1'b1, 12'h020, 4'b0000, 32'h0);
    repeat (3) @(negedge clk);
    drive(0, 1'b0, 12'h0, 4'b0000, 32'h0);
    wait_idle(0);

    // Zero wait states on dut_b.
    req(1, 12'h000, 4'b1111, 32'h5A5A5A5A, 0);
    req(1, 12'h000, 4'b0000, 32'h0, 0);
    req(1, 12'hFFC, 4'b1111, 32'h89ABCDEF, 0);
    @(negedge clk);
    expect_resp(1, 12'h000, 4'b0000, 32'h0, 0, cyc + 1);
    drive(1, 1'b1, 12'h000, 4'b0000, 32'h0);
    @(negedge clk);
    expect_resp(1, 12'hFFC, 4'b0000, 32'h0, 0, cyc + 2);
    drive(1, 1'b1, 12'hFFC, 4'b0000, 32'h0);
    repeat (2) @(negedge clk);
    drive(1, 1'b0, 12'h0, 4'b0000, 32'h0);
    wait_idle(1);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
